// File: rtl/conv3x3_scheduler.sv
// Sequencer for one shared 3x3 MAC: buffers a kernel and an IMG_H x IMG_W image from one stream,
// then presents every valid 3x3 window in raster order and returns one MAC result per window.
module conv3x3_scheduler #(
    parameter int DW      = 16,
    parameter int IMG_W   = 7,
    parameter int IMG_H   = 7,
    parameter int MAC_LAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [9*DW-1:0] k_flat,
    output logic [9*DW-1:0] w_flat,
    input  logic [DW-1:0]   mac_r,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(NPIX);
    localparam int RW   = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
    localparam int CW   = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1;
    localparam int LW   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 3);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 3);
    localparam logic [LW-1:0] L_LAST = LW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
    localparam logic [3:0]    K_LAST = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_LOAD_I = 3'd2,
        S_WIN    = 3'd3,
        S_WAIT   = 3'd4,
        S_CAP    = 3'd5,
        S_OUT    = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t            state_q;
    logic [3:0]        kcnt_q;
    logic [PW-1:0]     pcnt_q;
    logic [RW-1:0]     r_q;
    logic [CW-1:0]     c_q;
    logic [LW-1:0]     wcnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [DW-1:0]     out_data_q;
    logic [9*DW-1:0]   k_flat_q;
    logic [9*DW-1:0]   w_flat_q;
    logic [DW-1:0]     pix_q [NPIX];
    logic              in_beat_s;

    assign in_beat_s = in_valid & in_ready_q;

    // Linear pixel address of window tap (i,j) for the window anchored at (r,c).
    function automatic logic [PW-1:0] pix_idx(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                              input int i, input int j);
        pix_idx = PW'((int'(r) + i) * IMG_W + int'(c) + j);
    endfunction

    // Image buffer: never reset, written only by accepted pixel beats.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_I && in_beat_s) begin
            pix_q[pcnt_q] <= in_data;
        end
    end

    // Control FSM with all outputs, counters, kernel and window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kcnt_q      <= '0;
            pcnt_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            k_flat_q    <= '0;
            w_flat_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_LOAD_K;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        kcnt_q     <= '0;
                        pcnt_q     <= '0;
                    end
                end
                S_LOAD_K: begin
                    if (in_beat_s) begin
                        k_flat_q[int'(kcnt_q)*DW +: DW] <= in_data;
                        if (kcnt_q == K_LAST) begin
                            kcnt_q  <= '0;
                            state_q <= S_LOAD_I;
                        end else begin
                            kcnt_q <= kcnt_q + 4'd1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (in_beat_s) begin
                        if (pcnt_q == P_LAST) begin
                            pcnt_q     <= '0;
                            r_q        <= '0;
                            c_q        <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_WIN;
                        end else begin
                            pcnt_q <= pcnt_q + PW'(1);
                        end
                    end
                end
                S_WIN: begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            w_flat_q[(3*i+j)*DW +: DW] <= pix_q[pix_idx(r_q, c_q, i, j)];
                        end
                    end
                    wcnt_q  <= '0;
                    state_q <= (MAC_LAT > 0) ? S_WAIT : S_CAP;
                end
                S_WAIT: begin
                    if (wcnt_q == L_LAST) begin
                        wcnt_q  <= '0;
                        state_q <= S_CAP;
                    end else begin
                        wcnt_q <= wcnt_q + LW'(1);
                    end
                end
                S_CAP: begin
                    out_data_q  <= mac_r;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (c_q != C_LAST) begin
                            c_q     <= c_q + CW'(1);
                            state_q <= S_WIN;
                        end else if (r_q != R_LAST) begin
                            c_q     <= '0;
                            r_q     <= r_q + RW'(1);
                            state_q <= S_WIN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    r_q     <= '0;
                    c_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign k_flat    = k_flat_q;
    assign w_flat    = w_flat_q;
endmodule

// File: tb/tb_conv3x3_scheduler.sv
// Bench for conv3x3_scheduler: one instance with a combinational MAC, one with a 2-stage MAC,
// both fed from the same stream and checked against a direct convolution of the loaded data.
module tb_conv3x3_scheduler;
    localparam int DW = 16;
    localparam int W  = 7;
    localparam int H  = 7;
    localparam int NP = W * H;
    localparam int NR = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    always #5 clk = ~clk;

    logic [9*DW-1:0] k_flat0, w_flat0, k_flat2, w_flat2;
    logic [DW-1:0]   mac_r0, mac_r2, mac_d1, out_data0, out_data2;
    logic in_ready0, in_ready2, out_valid0, out_valid2, busy0, busy2, done0, done2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [DW-1:0] kern [9];
    logic [DW-1:0] img [NP];

    // External MAC: signed Q3.12 dot product of kernel and window, truncated to DW bits.
    function automatic logic [DW-1:0] mac(input logic [9*DW-1:0] k, input logic [9*DW-1:0] w);
        longint acc;
        acc = 0;
        for (int t = 0; t < 9; t++)
            acc += longint'($signed(k[t*DW +: DW])) * longint'($signed(w[t*DW +: DW]));
        return DW'(acc >>> 12);
    endfunction

    assign mac_r0 = mac(k_flat0, w_flat0);
    always @(posedge clk) begin
        mac_d1 <= mac(k_flat2, w_flat2);
        mac_r2 <= mac_d1;
    end
    always @(posedge clk) cyc <= cyc + 1;

    conv3x3_scheduler #(.DW(DW), .IMG_W(W), .IMG_H(H), .MAC_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .k_flat(k_flat0), .w_flat(w_flat0), .mac_r(mac_r0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .busy(busy0), .done(done0));

    conv3x3_scheduler #(.DW(DW), .IMG_W(W), .IMG_H(H), .MAC_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .k_flat(k_flat2), .w_flat(w_flat2), .mac_r(mac_r2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .busy(busy2), .done(done2));

    logic          ov [2];
    logic          dn [2];
    logic [DW-1:0] od [2];
    assign ov[0] = out_valid0;
    assign ov[1] = out_valid2;
    assign dn[0] = done0;
    assign dn[1] = done2;
    assign od[0] = out_data0;
    assign od[1] = out_data2;

    int            n [2];
    int            dcnt [2];
    int            first_v [2];
    int            hs_cyc [2][NR];
    logic [DW-1:0] res [2][NR];
    logic          pv [2] = '{1'b0, 1'b0};
    logic          phs [2] = '{1'b0, 1'b0};
    logic [DW-1:0] pd [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects handshakes, checks hold-while-stalled and done timing.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && pv[d] && !phs[d])
                chk($sformatf("hold%0d", d), {47'd0, ov[d], od[d]}, {47'd1, pd[d]});
            if (ov[d] && !pv[d] && first_v[d] < 0) first_v[d] = cyc;
            if (dn[d]) begin
                dcnt[d]++;
                chk($sformatf("done_after_last%0d", d), 64'(n[d]), 64'(NR));
            end
            if (ov[d] && out_ready) begin
                if (n[d] < NR) begin
                    res[d][n[d]]    = od[d];
                    hs_cyc[d][n[d]] = cyc;
                end
                n[d]++;
            end
            pv[d]  = ov[d];
            phs[d] = ov[d] && out_ready;
            pd[d]  = od[d];
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  {62'd0, in_ready2, in_ready0}, 64'd0);
        chk({tag, "_out_valid"}, {62'd0, out_valid2, out_valid0}, 64'd0);
        chk({tag, "_busy"},      {62'd0, busy2, busy0}, 64'd0);
        chk({tag, "_done"},      {62'd0, done2, done0}, 64'd0);
        chk({tag, "_out_data"},  {32'd0, out_data2, out_data0}, 64'd0);
        chk({tag, "_flat"},      {60'd0, |k_flat2, |w_flat2, |k_flat0, |w_flat0}, 64'd0);
    endtask

    // gap: 0 continuous, 1 toggling, 2 random in_valid. bp: 0 ready high, 1 random, 2 long stalls.
    task automatic run_job(input string tag, input int gap, input int bp, input bit abort7);
        logic [DW-1:0] words [9+NP];
        logic [DW-1:0] exp [NR];
        longint acc;
        int idx, budget, lb, st0, st24;
        for (int t = 0; t < 9; t++) words[t] = kern[t];
        for (int p = 0; p < NP; p++) words[9+p] = img[p];
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += longint'($signed(kern[3*i+j])) * longint'($signed(img[(r+i)*W + c + j]));
                exp[r*(W-2)+c] = DW'(acc >>> 12);
            end
        end
        for (int d = 0; d < 2; d++) begin
            n[d] = 0;
            dcnt[d] = 0;
            first_v[d] = -1;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idx = 0;
        lb = 0;
        budget = 1000;
        while (idx < 9 + NP && budget > 0) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (budget % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = words[idx];
            @(negedge clk);
            chk({tag, "_load_ready"}, {62'd0, in_ready2, in_ready0}, 64'd3);
            if (in_valid) begin
                idx++;
                lb = cyc;
            end
            budget--;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, "_load_timeout"}, 64'(idx), 64'(9 + NP));
        @(negedge clk);
        chk({tag, "_ready_after_load"}, {62'd0, in_ready2, in_ready0}, 64'd0);
        chk({tag, "_busy_run"}, {62'd0, busy2, busy0}, 64'd3);
        @(posedge clk); #1;
        budget = 3000;
        st0 = 0;
        st24 = 0;
        while (!(n[0] >= NR && n[1] >= NR && dcnt[0] > 0 && dcnt[1] > 0) && budget > 0) begin
            if (abort7 && n[0] == 7 && ov[0]) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_reset({tag, "_abort"});
                @(posedge clk); #1;
                start = 1'b0;
                out_ready = 1'b0;
                rst_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk({tag, "_no_done"}, 64'(dcnt[0] + dcnt[1]), 64'd0);
                return;
            end
            case (bp)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (ov[0] && n[0] == 0 && st0 < 10) begin
                        out_ready = 1'b0;
                        st0++;
                    end else if (ov[0] && n[0] == NR - 1 && st24 < 10) begin
                        out_ready = 1'b0;
                        st24++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            start = (bp == 1 && busy0 && busy2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            budget--;
        end
        start = 1'b0;
        chk({tag, "_result_timeout"}, 64'(budget > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_count%0d", tag, d), 64'(n[d]), 64'(NR));
            chk($sformatf("%s_done%0d", tag, d), 64'(dcnt[d]), 64'd1);
            chk($sformatf("%s_latency%0d", tag, d), 64'(first_v[d] - lb), 64'(3 + 2*d));
            for (int i = 0; i < NR && i < n[d]; i++)
                chk($sformatf("%s_res%0d_%0d", tag, d, i), 64'(res[d][i]), 64'(exp[i]));
            if (bp == 0)
                for (int i = 1; i < NR && i < n[d]; i++)
                    chk($sformatf("%s_period%0d_%0d", tag, d, i),
                        64'(hs_cyc[d][i] - hs_cyc[d][i-1]), 64'(3 + 2*d));
        end
        chk({tag, "_idle"}, {62'd0, busy2, busy0}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 16'h1000 : 16'h0000;
        for (int p = 0; p < NP; p++) img[p] = DW'(p << 8);
        run_job("ident", 0, 0, 1'b0);

        for (int t = 0; t < 9; t++) kern[t] = 16'h1000;
        for (int p = 0; p < NP; p++) img[p] = 16'h0100;
        run_job("box", 0, 0, 1'b0);

        for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 16'h1000 : 16'h0000;
        for (int p = 0; p < NP; p++) img[p] = DW'(p << 8);
        run_job("stall", 0, 2, 1'b0);
        run_job("gaps", 1, 0, 1'b0);

        for (int t = 0; t < 9; t++) kern[t] = DW'($urandom);
        for (int p = 0; p < NP; p++) img[p] = DW'($urandom);
        run_job("abort", 2, 1, 1'b1);

        for (int t = 0; t < 9; t++) kern[t] = DW'($urandom);
        for (int p = 0; p < NP; p++) img[p] = DW'($urandom);
        run_job("rand_bp", 2, 1, 1'b0);

        for (int t = 0; t < 9; t++) kern[t] = DW'($urandom);
        for (int p = 0; p < NP; p++) img[p] = DW'($urandom);
        run_job("rand", 2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
